// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore control FSM for the 32-bit multicycle CPU. Decodes the IR opcode
//   together with the current state and drives every datapath control strobe.
//   All outputs are a combinational decode of the state register and Opcode.
//
// Ports
//   Clk, Reset          clock, synchronous active-high reset
//   Opcode[5:0]         IR opcode field from the datapath
//   PCWrite, PCWriteCond, IRWrite, MemWrite, MemAddr, ALUSrcA, RegRead,
//   RegWrite            1-bit datapath strobes
//   PCSource, ALUSrcB, MemtoReg, BranchCond   2-bit mux selects
//   ALUSelect[2:0]      ALU operation
//   State[3:0]          current state encoding (debug)
//   Halted              high while in HALT
//   InstrCount[31:0]    retired-instruction counter
//
// Configuration
//   CTRL_PERF_CNT_EN    when defined, InstrCount is a live 32-bit counter;
//                       otherwise it is tied to zero and no flops exist.
module multicycle_control #(
  parameter logic [2:0] ALU_ADD = 3'b000,
  parameter logic [2:0] ALU_SUB = 3'b001
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [5:0]  Opcode,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        MemAddr,
  output logic        ALUSrcA,
  output logic        RegRead,
  output logic        RegWrite,
  output logic [1:0]  PCSource,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  MemtoReg,
  output logic [1:0]  BranchCond,
  output logic [2:0]  ALUSelect,
  output logic [3:0]  State,
  output logic        Halted,
  output logic [31:0] InstrCount
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_EXEC_R = 4'd3,
    S_EXEC_I = 4'd4,
    S_ALU_WB = 4'd5,
    S_MEM_RD = 4'd6,
    S_MEM_WB = 4'd7,
    S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_IMM_WB = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;

  logic w_is_sw, w_is_br;
  assign w_is_sw = (Opcode == 6'b100011);
  assign w_is_br = (Opcode[5:2] == 4'b1001);

  // Next-state logic; unknown opcodes fall through DECODE back to FETCH.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        w_next = S_FETCH;
        if      (Opcode[5:3] == 3'b010) w_next = S_EXEC_R;
        else if (Opcode[5:3] == 3'b011) w_next = S_EXEC_I;
        else if (Opcode == 6'b100000 || Opcode == 6'b100001) w_next = S_IMM_WB;
        else if (Opcode == 6'b100010) w_next = S_MEM_RD;
        else if (w_is_sw)             w_next = S_MEM_WR;
        else if (w_is_br)             w_next = S_BRANCH;
        else if (Opcode == 6'b101000) w_next = S_JUMP;
        else if (Opcode == 6'b111111) w_next = S_HALT;
      end
      S_EXEC_R, S_EXEC_I: w_next = S_ALU_WB;
      S_MEM_RD: w_next = S_MEM_WB;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) r_state <= S_INIT;
    else       r_state <= w_next;
  end

  assign State = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_instr_count;
  logic        w_retire;
  // An instruction retires when it re-enters FETCH from DECODE (NOP) or a
  // terminal state; INIT->FETCH is not an instruction.
  assign w_retire = (w_next == S_FETCH) && (r_state != S_INIT) && (r_state != S_FETCH);
  always_ff @(posedge Clk) begin
    if (Reset)         r_instr_count <= 32'h0;
    else if (w_retire) r_instr_count <= r_instr_count + 32'h1;
  end
  assign InstrCount = r_instr_count;
`else
  assign InstrCount = 32'h0;
`endif

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    MemAddr     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    MemtoReg    = 2'b00;
    BranchCond  = 2'b00;
    ALUSelect   = ALU_ADD;
    Halted      = 1'b0;
    // B port reads R1 for stores and branches once the opcode is valid.
    RegRead     = (w_is_sw || w_is_br) && (r_state != S_INIT) &&
                  (r_state != S_FETCH) && (r_state != S_HALT);
    case (r_state)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b10;  // branch target precompute into ALUout
      S_EXEC_R: begin
        ALUSrcA   = 1'b1;
        ALUSelect = Opcode[2:0];
      end
      S_EXEC_I: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUSelect = Opcode[2:0];
      end
      S_ALU_WB: RegWrite = 1'b1;
      S_MEM_RD: MemAddr = 1'b1;
      S_MEM_WB: begin
        MemAddr  = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      S_MEM_WR: begin
        MemAddr  = 1'b1;
        MemWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSelect   = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        BranchCond  = Opcode[1:0];
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_IMM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = Opcode[0] ? 2'b11 : 2'b01;
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [5:0]  Opcode;
  logic        PCWrite, PCWriteCond, IRWrite, MemWrite, MemAddr, ALUSrcA, RegRead, RegWrite;
  logic [1:0]  PCSource, ALUSrcB, MemtoReg, BranchCond;
  logic [2:0]  ALUSelect;
  logic [3:0]  State;
  logic        Halted;
  logic [31:0] InstrCount;

  multicycle_control dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .MemWrite(MemWrite), .MemAddr(MemAddr), .ALUSrcA(ALUSrcA),
    .RegRead(RegRead), .RegWrite(RegWrite), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .MemtoReg(MemtoReg), .BranchCond(BranchCond),
    .ALUSelect(ALUSelect), .State(State), .Halted(Halted),
    .InstrCount(InstrCount)
  );

  always #5 Clk = ~Clk;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_cnt = 0;

  typedef struct {
    logic [3:0]  st;
    logic [19:0] outs;
    bit          last;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] dut_outs();
    return {PCWrite, PCWriteCond, IRWrite, MemWrite, MemAddr, ALUSrcA, RegRead, RegWrite,
            PCSource, ALUSrcB, MemtoReg, BranchCond, ALUSelect, Halted};
  endfunction

  // Reference output table, one row per state.
  function automatic logic [19:0] model(input logic [3:0] st, input logic [5:0] op);
    logic pcw, pcwc, irw, mw, ma, asa, rr, rw, hlt;
    logic [1:0] pcs, asb, m2r, bc;
    logic [2:0] sel;
    {pcw, pcwc, irw, mw, ma, asa, rr, rw, hlt} = '0;
    {pcs, asb, m2r, bc} = '0;
    sel = 3'b000;
    case (st)
      4'd1:  begin irw = 1; pcw = 1; asb = 2'b01; end
      4'd2:  asb = 2'b10;
      4'd3:  begin asa = 1; sel = op[2:0]; end
      4'd4:  begin asa = 1; asb = 2'b10; sel = op[2:0]; end
      4'd5:  rw = 1;
      4'd6:  ma = 1;
      4'd7:  begin ma = 1; rw = 1; m2r = 2'b10; end
      4'd8:  begin ma = 1; mw = 1; end
      4'd9:  begin asa = 1; sel = 3'b001; pcwc = 1; pcs = 2'b01; bc = op[1:0]; end
      4'd10: begin pcw = 1; pcs = 2'b10; end
      4'd11: begin rw = 1; m2r = (op == 6'b100001) ? 2'b11 : 2'b01; end
      4'd12: hlt = 1;
      default: ;
    endcase
    if (st >= 4'd2 && st != 4'd12 && (op == 6'b100011 || op[5:2] == 4'b1001)) rr = 1;
    return {pcw, pcwc, irw, mw, ma, asa, rr, rw, pcs, asb, m2r, bc, sel, hlt};
  endfunction

  // Push the expected per-cycle trace for one instruction, FETCH up to (not
  // including) the next FETCH.
  task automatic push_instr(input logic [5:0] op, input int halt_cycles);
    logic [3:0] seq[$];
    seq = '{4'd1, 4'd2};
    if      (op[5:3] == 3'b010) seq = '{4'd1, 4'd2, 4'd3, 4'd5};
    else if (op[5:3] == 3'b011) seq = '{4'd1, 4'd2, 4'd4, 4'd5};
    else if (op == 6'b100000 || op == 6'b100001) seq = '{4'd1, 4'd2, 4'd11};
    else if (op == 6'b100010) seq = '{4'd1, 4'd2, 4'd6, 4'd7};
    else if (op == 6'b100011) seq = '{4'd1, 4'd2, 4'd8};
    else if (op[5:2] == 4'b1001) seq = '{4'd1, 4'd2, 4'd9};
    else if (op == 6'b101000) seq = '{4'd1, 4'd2, 4'd10};
    else if (op == 6'b111111) begin
      seq = '{4'd1, 4'd2};
      for (int i = 0; i < halt_cycles; i++) seq.push_back(4'd12);
    end
    foreach (seq[i]) begin
      exp_t e;
      e.st = seq[i];
      e.outs = model(seq[i], op);
      e.last = (i == seq.size() - 1) && (op != 6'b111111);
      sb.push_back(e);
    end
  endtask

  // Drive one instruction (called at a negedge while in FETCH) and drain the
  // scoreboard one cycle at a time.
  task automatic run_instr(input logic [5:0] op, input int halt_cycles);
    exp_t e;
    Opcode = op;
    push_instr(op, halt_cycles);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      chk($sformatf("state op=%b", op), State, e.st);
      chk($sformatf("outs op=%b st=%0d", op, e.st), dut_outs(), e.outs);
      @(negedge Clk);
      if (e.last) begin
`ifdef CTRL_PERF_CNT_EN
        exp_cnt = exp_cnt + 1;
`endif
        #1;
        chk($sformatf("cnt op=%b", op), InstrCount, exp_cnt);
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      #1;
      chk("rst state", State, 4'd0);
      chk("rst outs", dut_outs(), 20'h0);
      chk("rst cnt", InstrCount, 32'h0);
    end
    exp_cnt = 0;
    Reset = 1'b0;
    #1;
    chk("post-rst state", State, 4'd0);
    @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1;
    Opcode = 6'b000000;
    @(negedge Clk);
    do_reset();

    run_instr(6'b010011, 0);  // R-type, ALU op 011
    run_instr(6'b100010, 0);  // LW
    run_instr(6'b100011, 0);  // SW
    run_instr(6'b100110, 0);  // blt
    run_instr(6'b100101, 0);  // beq
    run_instr(6'b101000, 0);  // J
    run_instr(6'b100000, 0);  // LI
    run_instr(6'b100001, 0);  // LUI
    run_instr(6'b011001, 0);  // I-type sub
    run_instr(6'b110101, 0);  // unknown -> NOP
    run_instr(6'b000000, 0);  // NOP

    run_instr(6'b111111, 11); // HALT: DECODE then 11 cycles parked
    do_reset();

    // Reset mid-instruction while in MEM_RD.
    Opcode = 6'b100010;
    @(negedge Clk); @(negedge Clk);
    #1;
    chk("mid state6", State, 4'd6);
    Reset = 1'b1;
    @(negedge Clk);
    #1;
    chk("mid rst state", State, 4'd0);
    chk("mid rst outs", dut_outs(), 20'h0);
    do_reset();

    for (int i = 0; i < 5; i++) run_instr(6'b000000, 0);
    chk("5 nops cnt", InstrCount, exp_cnt);

`ifdef CTRL_PERF_CNT_EN
    chk("5 nops abs", InstrCount, 32'd5);
    force dut.r_instr_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_instr_count;
    exp_cnt = 32'hFFFF_FFFF;
    run_instr(6'b000000, 0);
    chk("wrap", InstrCount, 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style control FSM for the 32-bit multicycle CPU. Consumes the 6-bit opcode that the datapath's instruction register presents and drives every datapath control strobe: PC and IR write enables, ALU operand selects, ALU operation, memory and register-file controls, and branch condition. It sits directly upstream of the datapath, with its outputs wired port-for-port to the datapath inputs of the same names. It also exposes the current state and a halt flag for the top-level bench.

## Interface
Parameters:
- ALU_ADD, 3'b000, ALUSelect code for add.
- ALU_SUB, 3'b001, ALUSelect code for subtract.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clk.
- Opcode  in  6  instruction register opcode field (datapath Out_to_Control).
- PCWrite, PCWriteCond, IRWrite, MemWrite, MemAddr, ALUSrcA, RegRead, RegWrite  out  1 each  datapath strobes.
- PCSource, ALUSrcB, MemtoReg, BranchCond  out  2 each  datapath mux selects.
- ALUSelect  out  3  ALU operation.
- State  out  4  current state encoding, for debug.
- Halted  out  1  high while in HALT.
- InstrCount  out  32  retired-instruction count; see Configuration.

## Operation
- Opcode map:
  - 000000: NOP.
  - 010xxx: R-type, rd=R1, rs=R2, rt=R3, ALU op=Opcode[2:0].
  - 011xxx: I-type signed immediate, rd=R1, ALU op=Opcode[2:0].
  - 100000: LI.
  - 100001: LUI.
  - 100010: LW.
  - 100011: SW.
  - 1001xx: branch; BranchCond=Opcode[1:0] (00 bne, 01 beq, 10 blt, 11 ble); compares R2 against R1.
  - 101000: J.
  - 111111: HALT.
  - Any other opcode: NOP.
- States, with encodings:
  - INIT=0: all outputs 0. Next state FETCH.
  - FETCH=1: IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUSelect=ALU_ADD, PCSource=00. Next state DECODE.
  - DECODE=2: ALUSrcA=0, ALUSrcB=10, ALUSelect=ALU_ADD, which precomputes the branch target into the ALUout register. Next state by opcode: EXEC_R, EXEC_I, IMM_WB, MEM_RD, MEM_WR, BRANCH, JUMP, HALT; NOP goes to FETCH.
  - EXEC_R=3: ALUSrcA=1, ALUSrcB=00, ALUSelect=Opcode[2:0]. Next state ALU_WB.
  - EXEC_I=4: ALUSrcA=1, ALUSrcB=10, ALUSelect=Opcode[2:0]. Next state ALU_WB.
  - ALU_WB=5: RegWrite=1, MemtoReg=00. Next state FETCH.
  - MEM_RD=6: MemAddr=1. Next state MEM_WB.
  - MEM_WB=7: MemAddr=1, RegWrite=1, MemtoReg=10. Next state FETCH.
  - MEM_WR=8: MemAddr=1, MemWrite=1. Next state FETCH.
  - BRANCH=9: ALUSrcA=1, ALUSrcB=00, ALUSelect=ALU_SUB, PCWriteCond=1, PCSource=01, BranchCond=Opcode[1:0]. Next state FETCH.
  - JUMP=10: PCWrite=1, PCSource=10. Next state FETCH.
  - IMM_WB=11: RegWrite=1; MemtoReg=01 for LI, 11 for LUI. Next state FETCH.
  - HALT=12: all outputs 0, Halted=1. Stays in HALT until Reset.
- RegRead=1 in DECODE and every later state when the opcode is SW or a branch; RegRead=0 otherwise. This makes B read R1 for those instructions.
- Every output not listed for a state is 0.
- Outputs are a pure combinational decode of the state register and Opcode. No output is registered.
- Opcode is stable from DECODE until the next FETCH edge, because the IR updates only in FETCH.

## Timing
- Reset: on a Clk edge with Reset=1, State becomes INIT regardless of the current state, including mid-instruction and HALT. All outputs are 0 in the following cycle. FETCH follows one cycle after Reset deasserts.
- Latency in cycles, measured from FETCH to the next FETCH:
  - R-type, I-type, LW: 4.
  - SW, branch, J, LI, LUI: 3.
  - NOP and unknown opcodes: 2.
  - HALT: never exits.
- Write strobes are high for exactly one cycle per instruction: IRWrite, MemWrite, RegWrite, PCWriteCond, and PCWrite in JUMP.
- Branch taken or not taken uses the same 3 cycles. The FSM does not observe the branch outcome.

## Configuration
- CTRL_PERF_CNT_EN defined:
  - InstrCount is a 32-bit register, cleared to 0 by Reset.
  - It increments by 1 on each transition from DECODE or a terminal state (ALU_WB, MEM_WB, MEM_WR, BRANCH, JUMP, IMM_WB) into FETCH.
  - HALT transitions do not count.
  - It wraps from 0xFFFFFFFF to 0.
- CTRL_PERF_CNT_EN undefined: InstrCount is tied to 32'h0 and no counter flops exist.

## Test plan
- Reset held 3 cycles, then released: State=0 and all outputs 0 while Reset is high. First cycle after release: State=0. Next cycle: State=1 with IRWrite=1, PCWrite=1, ALUSrcB=01.
- Opcode=010011 (R-type): state sequence 1,2,3,5,1. ALUSelect=3'b011 in state 3. RegWrite=1 only in state 5, with MemtoReg=00. InstrCount 0 to 1 if enabled.
- Opcode=100010 (LW) then 100011 (SW):
  - LW sequence 1,2,6,7,1, with MemtoReg=10 in state 7.
  - SW sequence 1,2,8,1, with MemWrite=1 in state 8 only.
  - RegRead=1 throughout SW from DECODE onward.
- Opcode=100110 (blt): sequence 1,2,9,1. In state 9: BranchCond=10, PCWriteCond=1, PCSource=01, ALUSelect=3'b001.
- Opcode=111111: sequence 1,2,12, then stays at 12 for 10 cycles with Halted=1. Reset then returns State to 0. Reset asserted mid-instruction while in state 6 also gives State=0 on the next edge.
- CTRL_PERF_CNT_EN build: 5 NOPs give InstrCount=5. Forcing the counter to 0xFFFFFFFF, then one NOP, gives 0.
